// File: rtl/trace_pkg.sv
// ============================================================================
// Module      : trace_pkg
// Description : Shared types, DDR field positions and address decode for the
//               trace request queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    // Widths of the stored record; top-level parameters must not exceed these.
    localparam int REC_TIME_W = 64;
    localparam int REC_CORE_W = 12;
    localparam int REC_ADDR_W = 36;

    localparam int ROW_LSB    = 18;
    localparam int ROW_W      = 16;
    localparam int BANK_LSB   = 9;
    localparam int BANK_W     = 2;
    localparam int BG_LSB     = 6;
    localparam int BG_W       = 3;
    localparam int COL_HI_LSB = 12;
    localparam int COL_HI_W   = 6;
    localparam int COL_LO_LSB = 2;
    localparam int COL_LO_W   = 4;
    localparam int COL_W      = COL_HI_W + COL_LO_W;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef struct packed {
        logic [REC_TIME_W-1:0] tstamp;
        logic [REC_CORE_W-1:0] core;
        op_e                   op;
        logic [REC_ADDR_W-1:0] addr;
    } trace_rec_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BANK_W-1:0] bank;
        logic [BG_W-1:0]   bg;
        logic [COL_W-1:0]  col;
    } ddr_addr_t;

    function automatic ddr_addr_t decode_addr(input logic [REC_ADDR_W-1:0] addr);
        ddr_addr_t d;
        d.row  = addr[ROW_LSB +: ROW_W];
        d.bank = addr[BANK_LSB +: BANK_W];
        d.bg   = addr[BG_LSB +: BG_W];
        d.col  = {addr[COL_HI_LSB +: COL_HI_W], addr[COL_LO_LSB +: COL_LO_W]};
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module      : trace_fifo
// Description : DEPTH-entry FIFO of trace records with wrap-bit pointers,
//               occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  trace_rec_t               wdata_i,
    output trace_rec_t               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers share the index bits; the extra MSB tells full from empty.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload is not reset; a write during reset is harmless because the
    // pointers are cleared in the same edge.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trace_req_queue.sv
// ============================================================================
// Module      : trace_req_queue
// Description : Buffers decoded trace records and releases each one when the
//               internal simulation clock reaches its timestamp; adds order
//               and illegal-op checks, idle skipping and DDR address decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_req_queue
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TIME_W    = 64,
    parameter int CORE_W    = 12,
    parameter int ADDR_W    = 36,
    parameter bit SKIP_IDLE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TIME_W-1:0]        in_time,
    input  logic [CORE_W-1:0]        in_core,
    input  logic [1:0]               in_op,
    input  logic [ADDR_W-1:0]        in_addr,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TIME_W-1:0]        out_time,
    output logic [CORE_W-1:0]        out_core,
    output logic [1:0]               out_op,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [15:0]              out_row,
    output logic [1:0]               out_bank,
    output logic [2:0]               out_bg,
    output logic [9:0]               out_col,

    output logic [TIME_W-1:0]        now,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_order,
    output logic                     err_op
);

    logic [TIME_W-1:0] now_q;
    logic [TIME_W-1:0] now_d;
    logic [TIME_W-1:0] last_time_q;
    logic [TIME_W-1:0] last_time_d;
    logic              err_order_q;
    logic              err_order_d;
    logic              err_op_q;
    logic              err_op_d;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_late;
    logic [TIME_W-1:0] w_store_time;
    logic [TIME_W-1:0] w_head_time;
    trace_rec_t        w_wrec;
    trace_rec_t        w_head;
    ddr_addr_t         w_dec;

    assign in_ready  = !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && (in_op != OP_ILLEGAL);

    assign w_head_time = w_head.tstamp[TIME_W-1:0];
    assign out_valid   = !w_empty && (w_head_time <= now_q);
    assign w_pop       = out_valid && out_ready;

    // Late records are clamped so the stored stream stays non-decreasing.
    assign w_late       = (in_time < last_time_q);
    assign w_store_time = w_late ? last_time_q : in_time;

    always_comb begin
        w_wrec        = '0;
        w_wrec.tstamp = REC_TIME_W'(w_store_time);
        w_wrec.core   = REC_CORE_W'(in_core);
        w_wrec.op     = op_e'(in_op);
        w_wrec.addr   = REC_ADDR_W'(in_addr);
    end

    trace_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wrec),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count)
    );

    always_comb begin
        last_time_d = last_time_q;
        err_order_d = err_order_q;
        err_op_d    = err_op_q;
        if (w_push) begin
            if (w_late) begin
                err_order_d = 1'b1;
            end else begin
                last_time_d = in_time;
            end
        end
        if (w_accept && (in_op == OP_ILLEGAL)) begin
            err_op_d = 1'b1;
        end
    end

    // With idle skipping, jump straight to a future head instead of counting.
    always_comb begin
        now_d = now_q;
        if (SKIP_IDLE && !w_empty && (w_head_time > now_q)) begin
            now_d = w_head_time;
        end else if (now_q != {TIME_W{1'b1}}) begin
            now_d = now_q + TIME_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q       <= '0;
            last_time_q <= '0;
            err_order_q <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            now_q       <= now_d;
            last_time_q <= last_time_d;
            err_order_q <= err_order_d;
            err_op_q    <= err_op_d;
        end
    end

    assign w_dec     = decode_addr(w_head.addr);

    assign out_time  = w_head_time;
    assign out_core  = w_head.core[CORE_W-1:0];
    assign out_op    = w_head.op;
    assign out_addr  = w_head.addr[ADDR_W-1:0];
    assign out_row   = w_dec.row;
    assign out_bank  = w_dec.bank;
    assign out_bg    = w_dec.bg;
    assign out_col   = w_dec.col;

    assign now       = now_q;
    assign err_order = err_order_q;
    assign err_op    = err_op_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_req_queue.sv
// ============================================================================
// Module      : tb_trace_req_queue
// Description : Randomised scoreboard bench for trace_req_queue, with a second
//               instance exercising idle skipping.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trace_req_queue;

    localparam int DEPTH  = 16;
    localparam int TIME_W = 64;
    localparam int CORE_W = 12;
    localparam int ADDR_W = 36;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: SKIP_IDLE = 0, fully scoreboarded.
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TIME_W-1:0] in_time  = '0;
    logic [CORE_W-1:0] in_core  = '0;
    logic [1:0]        in_op    = '0;
    logic [ADDR_W-1:0] in_addr  = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TIME_W-1:0] out_time;
    logic [CORE_W-1:0] out_core;
    logic [1:0]        out_op;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_row;
    logic [1:0]        out_bank;
    logic [2:0]        out_bg;
    logic [9:0]        out_col;
    logic [TIME_W-1:0] now;
    logic [CNT_W-1:0]  count;
    logic              err_order;
    logic              err_op;

    // Instance 1: SKIP_IDLE = 1.
    logic              s_in_valid = 1'b0;
    logic              s_in_ready;
    logic [TIME_W-1:0] s_in_time  = '0;
    logic [CORE_W-1:0] s_in_core  = '0;
    logic [1:0]        s_in_op    = '0;
    logic [ADDR_W-1:0] s_in_addr  = '0;
    logic              s_out_valid;
    logic              s_out_ready = 1'b0;
    logic [TIME_W-1:0] s_out_time;
    logic [CORE_W-1:0] s_out_core;
    logic [1:0]        s_out_op;
    logic [ADDR_W-1:0] s_out_addr;
    logic [15:0]       s_out_row;
    logic [1:0]        s_out_bank;
    logic [2:0]        s_out_bg;
    logic [9:0]        s_out_col;
    logic [TIME_W-1:0] s_now;
    logic [CNT_W-1:0]  s_count;
    logic              s_err_order;
    logic              s_err_op;

    trace_req_queue #(
        .DEPTH(DEPTH), .TIME_W(TIME_W), .CORE_W(CORE_W), .ADDR_W(ADDR_W), .SKIP_IDLE(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time), .in_core(in_core),
        .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time), .out_core(out_core),
        .out_op(out_op), .out_addr(out_addr), .out_row(out_row), .out_bank(out_bank),
        .out_bg(out_bg), .out_col(out_col), .now(now), .count(count),
        .err_order(err_order), .err_op(err_op)
    );

    trace_req_queue #(
        .DEPTH(DEPTH), .TIME_W(TIME_W), .CORE_W(CORE_W), .ADDR_W(ADDR_W), .SKIP_IDLE(1'b1)
    ) dut_skip (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_time(s_in_time), .in_core(s_in_core),
        .in_op(s_in_op), .in_addr(s_in_addr),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_time(s_out_time),
        .out_core(s_out_core), .out_op(s_out_op), .out_addr(s_out_addr), .out_row(s_out_row),
        .out_bank(s_out_bank), .out_bg(s_out_bg), .out_col(s_out_col), .now(s_now),
        .count(s_count), .err_order(s_err_order), .err_op(s_err_op)
    );

    typedef struct {
        logic [63:0] t;
        logic [11:0] core;
        logic [1:0]  op;
        logic [35:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_last      = '0;
    logic [63:0] model_now       = '0;
    bit          model_err_order = 1'b0;
    bit          model_err_op    = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] m_row(input logic [63:0] a);
        return 16'((a / 64'd262144) % 64'd65536);
    endfunction
    function automatic logic [1:0] m_bank(input logic [63:0] a);
        return 2'((a / 64'd512) % 64'd4);
    endfunction
    function automatic logic [2:0] m_bg(input logic [63:0] a);
        return 3'((a / 64'd64) % 64'd8);
    endfunction
    function automatic logic [9:0] m_col(input logic [63:0] a);
        return 10'(((a / 64'd4096) % 64'd64) * 64'd16 + (a / 64'd4) % 64'd16);
    endfunction

    task automatic model_accept(input logic [63:0] t, input logic [11:0] c,
                                input logic [1:0] op, input logic [35:0] a);
        exp_t e;
        if (op == 2'd3) begin
            model_err_op = 1'b1;
        end else begin
            if (t < model_last) begin
                model_err_order = 1'b1;
                e.t = model_last;
            end else begin
                e.t = t;
                model_last = t;
            end
            e.core = c;
            e.op   = op;
            e.addr = a;
            exp_q.push_back(e);
        end
    endtask

    // One cycle of offering; called at posedge+1, returns at the next posedge+1.
    task automatic cycle_push(input bit v, input logic [63:0] t, input logic [11:0] c,
                              input logic [1:0] op, input logic [35:0] a, output bit acc);
        in_valid = v;
        in_time  = t;
        in_core  = c;
        in_op    = op;
        in_addr  = a;
        @(negedge clk);
        acc = v && in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) model_accept(t, c, op, a);
    endtask

    task automatic send(input logic [63:0] t, input logic [11:0] c,
                        input logic [1:0] op, input logic [35:0] a);
        bit acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            cycle_push(1'b1, t, c, op, a, acc);
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset(input bit with_push);
        rst      = 1'b1;
        in_valid = with_push;
        in_time  = 64'd3;
        in_op    = 2'd0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_last      = '0;
        model_err_order = 1'b0;
        model_err_op    = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 3000 && count != 0; i++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check(name, 64'(count), 64'd0);
    endtask

    // Monitor: checks every cycle against the model, then retires a popped head.
    always @(negedge clk) begin
        if (rst) begin
            model_now = '0;
        end else begin
            check("count", 64'(count), 64'(exp_q.size()));
            check("now", now, model_now);
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            check("err_order", 64'(err_order), 64'(model_err_order));
            check("err_op", 64'(err_op), 64'(model_err_op));
            if (exp_q.size() == 0) begin
                check("out_valid_empty", 64'(out_valid), 64'd0);
            end else begin
                check("out_valid", 64'(out_valid), 64'(exp_q[0].t <= model_now));
                check("out_time", out_time, exp_q[0].t);
                check("out_core", 64'(out_core), 64'(exp_q[0].core));
                check("out_op", 64'(out_op), 64'(exp_q[0].op));
                check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                check("out_row", 64'(out_row), 64'(m_row(64'(exp_q[0].addr))));
                check("out_bank", 64'(out_bank), 64'(m_bank(64'(exp_q[0].addr))));
                check("out_bg", 64'(out_bg), 64'(m_bg(64'(exp_q[0].addr))));
                check("out_col", 64'(out_col), 64'(m_col(64'(exp_q[0].addr))));
                if (out_valid && out_ready) void'(exp_q.pop_front());
            end
            if (model_now != 64'hFFFF_FFFF_FFFF_FFFF) model_now = model_now + 64'd1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          acc;
        logic [63:0] t;
        int          cnt0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_now", now, 64'd0);

        // Idle skip: push a far-future record while now == 3.
        for (int i = 0; i < 20 && s_now != 64'd3; i++) @(negedge clk);
        check("skip_now3", s_now, 64'd3);
        s_in_valid = 1'b1;
        s_in_time  = 64'd1000;
        s_in_core  = 12'h7;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("skip_pre_now", s_now, 64'd4);
        check("skip_pre_valid", 64'(s_out_valid), 64'd0);
        check("skip_pre_count", 64'(s_count), 64'd1);
        @(negedge clk);
        check("skip_jump_now", s_now, 64'd1000);
        check("skip_valid", 64'(s_out_valid), 64'd1);
        check("skip_out_time", s_out_time, 64'd1000);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        check("skip_popped", 64'(s_count), 64'd0);
        @(posedge clk);
        #1;

        // First record becomes due exactly at now == 5.
        do_reset(1'b0);
        send(64'd5, 12'd1, 2'd0, 36'h0_0004_0A44);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("first_due_now", now, 64'd5);
        check("first_row", 64'(out_row), 64'h0001);
        check("first_bank", 64'(out_bank), 64'd1);
        check("first_bg", 64'(out_bg), 64'd1);
        check("first_col", 64'(out_col), 64'h001);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Fill to DEPTH, pop one, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            send(model_last + 64'(i % 2), 12'(i + 100), 2'(i % 3), 36'($urandom));
        end
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count", 64'(count), 64'(DEPTH));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        check("full_pop_count", 64'(count), 64'(DEPTH - 1));
        @(posedge clk);
        #1;
        drain("full_drain");

        // Out-of-order timestamps are clamped to the last accepted time.
        do_reset(1'b0);
        send(64'd10, 12'd2, 2'd1, 36'h1_2345_6789);
        send(64'd7, 12'd3, 2'd2, 36'h2_0000_0FFC);
        @(negedge clk);
        check("order_err", 64'(err_order), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("order_clamped_time", out_time, 64'd10);
        @(posedge clk);
        #1;

        // Illegal op is consumed but not stored.
        cnt0 = int'(count);
        send(model_last, 12'd4, 2'd3, 36'h0_0000_0040);
        @(negedge clk);
        check("illegal_count", 64'(count), 64'(cnt0));
        check("illegal_err", 64'(err_op), 64'd1);
        @(posedge clk);
        #1;
        drain("illegal_drain");

        // Reset with entries queued and a push offered.
        for (int i = 0; i < 4; i++) send(model_last + 64'd1000, 12'(i), 2'd0, 36'($urandom));
        @(negedge clk);
        check("pre_rst_count", 64'(count), 64'd4);
        @(posedge clk);
        #1;
        do_reset(1'b1);
        @(negedge clk);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_now", now, 64'd0);
        check("mid_rst_err_order", 64'(err_order), 64'd0);
        check("mid_rst_err_op", 64'(err_op), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with occasional late timestamps.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0 && model_last >= 64'd3) begin
                t = model_last - 64'd3;
            end else begin
                t = model_last + 64'($urandom_range(0, 2));
            end
            cycle_push($urandom_range(0, 2) != 0, t, 12'($urandom),
                       2'($urandom_range(0, 2)), 36'({$urandom, $urandom}), acc);
        end
        drain("random_drain");

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
